// File: rtl/table_tile_renderer_pkg.sv
// Shared constants, state encoding and glyph helpers
// for the poker table tile renderer.
package table_tile_renderer_pkg;

  localparam logic [7:0] GLYPH_RANK_BASE  = 8'h40;
  localparam logic [7:0] GLYPH_SUIT_BASE  = 8'h50;
  localparam logic [7:0] GLYPH_DIGIT_BASE = 8'h30;
  localparam logic [7:0] GLYPH_BLANK      = 8'h20;
  localparam logic [7:0] GLYPH_GAME_OVER  = 8'h7F;

  localparam int CARD_BASE    = 0;
  localparam int POT_BASE     = 18;
  localparam int P1_BANK_BASE = 21;
  localparam int P2_BANK_BASE = 24;
  localparam int STATUS_ADDR  = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SNAP,
    ST_CONVERT,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [7:0] card_glyph(
    input logic [5:0] card,
    input logic       is_suit
  );
    if (card[3:0] == 4'd0 || card[3:0] > 4'd13)
      return GLYPH_BLANK;
    else if (is_suit)
      return GLYPH_SUIT_BASE + {6'b0, card[5:4]};
    else
      return GLYPH_RANK_BASE + {4'b0, card[3:0]};
  endfunction

  // pos 0 = hundreds, 1 = tens, 2 = ones
  function automatic logic [7:0] digit_glyph(
    input logic [11:0] bcd,
    input logic [1:0]  pos
  );
    logic [3:0] n;
    case (pos)
      2'd0:    n = bcd[11:8];
      2'd1:    n = bcd[7:4];
      default: n = bcd[3:0];
    endcase
    return GLYPH_DIGIT_BASE + {4'b0, n};
  endfunction

endpackage

// File: rtl/table_tile_renderer_bin_to_bcd8.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD,
// one start cycle then eight shift cycles.
module bin_to_bcd8
  import table_tile_renderer_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic [11:0] w_adj;
  logic [11:0] w_next;

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign w_adj  = {adj(r_bcd[11:8]),
                   adj(r_bcd[7:4]),
                   adj(r_bcd[3:0])};
  assign w_next = {w_adj[10:0], r_bin[7]};

  // Result is presented during the final shift cycle
  assign o_done = r_busy && (r_cnt == 3'd7) && !i_start;
  assign o_bcd  = w_next;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bin  <= {r_bin[6:0], 1'b0};
      r_bcd  <= w_next;
      r_cnt  <= r_cnt + 3'd1;
      if (r_cnt == 3'd7)
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/table_tile_renderer.sv
// Snapshots table state on change and streams 28 glyph
// tiles to the VGA tile RAM, then flags the screen done.
module table_tile_renderer
  import table_tile_renderer_pkg::*;
#(
  parameter int TILE_AW = 6,
  parameter int GLYPH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               change,
  input  logic [5:0]         P1C1,
  input  logic [5:0]         P1C2,
  input  logic [5:0]         P2C1,
  input  logic [5:0]         P2C2,
  input  logic [17:0]        flop,
  input  logic [5:0]         turn,
  input  logic [5:0]         river,
  input  logic [7:0]         pot,
  input  logic [7:0]         p1_bank,
  input  logic [7:0]         p2_bank,
  input  logic               game_over,
  output logic               wr_en,
  output logic [TILE_AW-1:0] wr_addr,
  output logic [GLYPH_W-1:0] wr_data,
  input  logic               wr_ready,
  output logic               done_draw_screen
);

  state_t r_state, w_next;

  logic [8:0][5:0]     r_card;
  logic [2:0][7:0]     r_money;
  logic [2:0][11:0]    r_bcd;
  logic                r_go;
  logic                r_done;
  logic                r_need_start;
  logic [1:0]          r_cidx;
  logic [TILE_AW-1:0]  r_addr;

  logic        w_start;
  logic        w_cdone;
  logic [11:0] w_bcd;
  logic [7:0]  w_conv_in;
  logic        w_acc;
  logic        w_last;
  logic [7:0]  w_glyph;
  logic        w_is_card;
  logic        w_is_pot;
  logic        w_is_p1;
  logic        w_is_p2;
  logic        w_is_stat;

  assign wr_en   = (r_state == ST_WRITE);
  assign wr_addr = wr_en ? r_addr : '0;
  assign wr_data = wr_en ? GLYPH_W'(w_glyph) : '0;
  assign done_draw_screen = r_done;

  assign w_acc   = wr_en && wr_ready;
  assign w_last  = (r_addr == TILE_AW'(STATUS_ADDR));
  assign w_start = (r_state == ST_CONVERT) && r_need_start;

  always_comb begin
    case (r_cidx)
      2'd0:    w_conv_in = r_money[0];
      2'd1:    w_conv_in = r_money[1];
      default: w_conv_in = r_money[2];
    endcase
  end

  bin_to_bcd8 u_bcd (
    .clk     (clk),
    .i_rst_n (rst),
    .i_start (w_start),
    .i_bin   (w_conv_in),
    .o_done  (w_cdone),
    .o_bcd   (w_bcd)
  );

  assign w_is_card = r_addr < TILE_AW'(POT_BASE);
  assign w_is_pot  = !w_is_card &&
                     r_addr < TILE_AW'(P1_BANK_BASE);
  assign w_is_p1   = r_addr >= TILE_AW'(P1_BANK_BASE) &&
                     r_addr < TILE_AW'(P2_BANK_BASE);
  assign w_is_p2   = r_addr >= TILE_AW'(P2_BANK_BASE) &&
                     r_addr < TILE_AW'(STATUS_ADDR);
  assign w_is_stat = w_last;

  always_comb begin
    w_glyph = GLYPH_BLANK;
    unique case (1'b1)
      w_is_card:
        w_glyph = card_glyph(r_card[r_addr[4:1]],
                             r_addr[0]);
      w_is_pot:
        w_glyph = digit_glyph(r_bcd[0],
          2'(r_addr - TILE_AW'(POT_BASE)));
      w_is_p1:
        w_glyph = digit_glyph(r_bcd[1],
          2'(r_addr - TILE_AW'(P1_BANK_BASE)));
      w_is_p2:
        w_glyph = digit_glyph(r_bcd[2],
          2'(r_addr - TILE_AW'(P2_BANK_BASE)));
      w_is_stat:
        w_glyph = r_go ? GLYPH_GAME_OVER : GLYPH_BLANK;
      default:
        w_glyph = GLYPH_BLANK;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    w_next = ST_IDLE;
      ST_ARM:     w_next = ST_SNAP;
      ST_SNAP:    w_next = ST_CONVERT;
      ST_CONVERT:
        if (w_cdone && r_cidx == 2'd2)
          w_next = ST_WRITE;
      ST_WRITE:
        if (w_acc && w_last)
          w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    // A new change always restarts the pass
    if (change)
      w_next = ST_ARM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_card       <= '0;
      r_money      <= '0;
      r_bcd        <= '0;
      r_go         <= 1'b0;
      r_done       <= 1'b0;
      r_need_start <= 1'b0;
      r_cidx       <= '0;
      r_addr       <= '0;
    end else begin
      case (r_state)
        ST_SNAP: begin
          r_card <= {river, turn, flop[17:12],
                     flop[11:6], flop[5:0],
                     P2C2, P2C1, P1C2, P1C1};
          r_money      <= {p2_bank, p1_bank, pot};
          r_go         <= game_over;
          r_done       <= 1'b0;
          r_addr       <= '0;
          r_cidx       <= '0;
          r_need_start <= 1'b1;
        end
        ST_CONVERT: begin
          if (w_start)
            r_need_start <= 1'b0;
          if (w_cdone) begin
            r_bcd[r_cidx] <= w_bcd;
            if (r_cidx != 2'd2) begin
              r_cidx       <= r_cidx + 2'd1;
              r_need_start <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (w_acc && !w_last)
            r_addr <= r_addr + 1'b1;
          if (w_acc && w_last && !change)
            r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_table_tile_renderer.sv
// Directed bench for table_tile_renderer: table-driven tile
// contents plus stall, abort and reset sequences.
module tb_table_tile_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        change = 1'b0;
  logic [5:0]  P1C1 = '0, P1C2 = '0, P2C1 = '0, P2C2 = '0;
  logic [17:0] flop = '0;
  logic [5:0]  turn = '0, river = '0;
  logic [7:0]  pot = '0, p1_bank = '0, p2_bank = '0;
  logic        game_over = 1'b0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready = 1'b1;
  logic        done_draw_screen;

  table_tile_renderer #(.TILE_AW(6), .GLYPH_W(8)) dut (
    .clk(clk), .rst(rst), .change(change),
    .P1C1(P1C1), .P1C2(P1C2), .P2C1(P2C1), .P2C2(P2C2),
    .flop(flop), .turn(turn), .river(river),
    .pot(pot), .p1_bank(p1_bank), .p2_bank(p2_bank),
    .game_over(game_over),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .done_draw_screen(done_draw_screen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  c1, c2, c3, c4;
    logic [17:0] flop;
    logic [5:0]  turn, river;
    logic [7:0]  pot, b1, b2;
    logic        go;
  } scen_t;

  typedef struct {
    int         sc;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  scen_t sc_tab[3];
  vec_t  vq[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] mem[28];
  int  q[$];
  int  n_acc = 0;
  int  first_cyc = 0;
  int  last_cyc = 0;
  bit  done_early = 0;
  int  c0 = 0;

  bit   stall_mode = 0;
  int   ph = 0;
  logic prev_stall = 1'b0;
  logic [5:0] p_addr = '0;
  logic [7:0] p_data = '0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_stall && rst) begin
      checks++;
      if (!wr_en || wr_addr != p_addr || wr_data != p_data) begin
        errors++;
        $display("FAIL stall_hold: en %0d addr %0d data %h, expected en 1 addr %0d data %h",
                 wr_en, wr_addr, wr_data, p_addr, p_data);
      end
    end
    prev_stall = rst && wr_en && !wr_ready;
    p_addr = wr_addr;
    p_data = wr_data;
    if (wr_en && wr_ready) begin
      if (wr_addr < 28) mem[wr_addr] = wr_data;
      q.push_back(int'(wr_addr));
      if (n_acc == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_acc++;
      if (done_draw_screen) done_early = 1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_mode) begin
      ph = (ph + 1) % 3;
      wr_ready = (ph == 0);
    end else begin
      wr_ready = 1'b1;
    end
  end

  task automatic add(input int s, input int a,
                     input logic [7:0] e);
    vec_t v;
    v.sc = s; v.addr = a; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic apply(input int s);
    P1C1 = sc_tab[s].c1; P1C2 = sc_tab[s].c2;
    P2C1 = sc_tab[s].c3; P2C2 = sc_tab[s].c4;
    flop = sc_tab[s].flop;
    turn = sc_tab[s].turn; river = sc_tab[s].river;
    pot = sc_tab[s].pot;
    p1_bank = sc_tab[s].b1; p2_bank = sc_tab[s].b2;
    game_over = sc_tab[s].go;
  endtask

  task automatic scramble();
    P1C1 = 6'($urandom); P1C2 = 6'($urandom);
    P2C1 = 6'($urandom); P2C2 = 6'($urandom);
    flop = 18'($urandom);
    turn = 6'($urandom); river = 6'($urandom);
    pot = 8'($urandom); p1_bank = 8'($urandom);
    p2_bank = 8'($urandom); game_over = ~game_over;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 28; i++) mem[i] = 8'hEE;
    q.delete();
    n_acc = 0;
    done_early = 0;
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    change = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    change = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_draw_screen) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_acc(input int a, input string nm);
    bit found = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (wr_en && wr_ready && wr_addr == 6'(a)) begin
        found = 1;
        break;
      end
    end
    chk(nm, int'(found), 1);
  endtask

  task automatic check_scen(input int s);
    foreach (vq[i])
      if (vq[i].sc == s)
        chk($sformatf("sc%0d_addr%0d", s, vq[i].addr),
            int'(mem[vq[i].addr]), int'(vq[i].exp));
  endtask

  task automatic check_order(input string nm, input int skip);
    int bad = 0;
    foreach (q[i]) begin
      int e = (i < skip) ? i : i - skip;
      if (q[i] != e) bad++;
    end
    chk(nm, bad, 0);
  endtask

  task automatic render(input int s, input bit timed,
                        output int dc);
    apply(s);
    clear_log();
    pulse();
    repeat (3) @(posedge clk);
    scramble();
    @(negedge clk);
    chk("done_cleared", int'(done_draw_screen), 0);
    wait_done(dc);
    chk("n_writes", n_acc, 28);
    check_order("write_order", 0);
    chk("done_early", int'(done_early), 0);
    if (timed) begin
      chk("first_write_cyc", first_cyc - c0, 30);
      chk("last_write_cyc", last_cyc - c0, 57);
      chk("done_cyc", dc - c0, 58);
    end
    check_scen(s);
  endtask

  initial begin
    int dc;
    int c1;
    int na;

    sc_tab[0] = '{c1: 6'h31, c2: 6'h00, c3: 6'h00,
                  c4: 6'h00, flop: 18'h0, turn: 6'h00,
                  river: 6'h00, pot: 8'd0, b1: 8'd0,
                  b2: 8'd0, go: 1'b0};
    sc_tab[1] = '{c1: 6'h00, c2: 6'h2C, c3: 6'h1D,
                  c4: 6'h0E, flop: 18'h0, turn: 6'h00,
                  river: 6'h00, pot: 8'd205, b1: 8'd0,
                  b2: 8'd255, go: 1'b0};
    sc_tab[2] = '{c1: 6'h10, c2: 6'h00, c3: 6'h00,
                  c4: 6'h00,
                  flop: {6'h2D, 6'h1A, 6'h05},
                  turn: 6'h3F, river: 6'h00,
                  pot: 8'd99, b1: 8'd100, b2: 8'd9,
                  go: 1'b1};

    add(0, 0, 8'h41);  add(0, 1, 8'h53);
    add(0, 2, 8'h20);  add(0, 3, 8'h20);
    add(0, 9, 8'h20);  add(0, 17, 8'h20);
    add(0, 18, 8'h30); add(0, 20, 8'h30);
    add(0, 26, 8'h30); add(0, 27, 8'h20);

    add(1, 2, 8'h4C);  add(1, 3, 8'h52);
    add(1, 4, 8'h4D);  add(1, 5, 8'h51);
    add(1, 6, 8'h20);  add(1, 7, 8'h20);
    add(1, 18, 8'h32); add(1, 19, 8'h30);
    add(1, 20, 8'h35); add(1, 21, 8'h30);
    add(1, 22, 8'h30); add(1, 23, 8'h30);
    add(1, 24, 8'h32); add(1, 25, 8'h35);
    add(1, 26, 8'h35); add(1, 27, 8'h20);

    add(2, 0, 8'h20);  add(2, 1, 8'h20);
    add(2, 8, 8'h45);  add(2, 9, 8'h50);
    add(2, 10, 8'h4A); add(2, 11, 8'h51);
    add(2, 12, 8'h4D); add(2, 13, 8'h52);
    add(2, 14, 8'h20); add(2, 15, 8'h20);
    add(2, 16, 8'h20); add(2, 17, 8'h20);
    add(2, 18, 8'h30); add(2, 19, 8'h39);
    add(2, 20, 8'h39); add(2, 21, 8'h31);
    add(2, 22, 8'h30); add(2, 23, 8'h30);
    add(2, 24, 8'h30); add(2, 25, 8'h30);
    add(2, 26, 8'h39); add(2, 27, 8'h7F);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_done", int'(done_draw_screen), 0);
    rst = 1'b1;

    // Main rendering with wr_ready tied high
    for (int s = 0; s < 3; s++)
      render(s, 1'b1, dc);

    // Input changes without change are ignored
    scramble();
    repeat (20) @(negedge clk);
    chk("idle_no_writes", n_acc, 28);
    chk("done_holds", int'(done_draw_screen), 1);

    // Stalled handshake: 1 cycle ready, 2 cycles not
    stall_mode = 1;
    render(1, 1'b0, dc);
    chk("stall_done_after_last", dc - last_cyc, 1);
    stall_mode = 0;
    repeat (2) @(posedge clk);

    // Abort at addr 10 acceptance
    apply(1);
    clear_log();
    pulse();
    wait_acc(10, "abort_reach10");
    apply(2);
    change = 1'b1;
    c1 = cyc;
    @(posedge clk);
    #1;
    change = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_done_low", int'(done_draw_screen), 0);
    wait_done(dc);
    chk("abort_n_writes", n_acc, 39);
    check_order("abort_order", 11);
    chk("abort_done_cyc", dc - c1, 58);
    check_scen(2);

    // Change coinciding with the final acceptance
    apply(0);
    clear_log();
    pulse();
    wait_acc(27, "fin_reach27");
    apply(1);
    change = 1'b1;
    @(posedge clk);
    #1;
    change = 1'b0;
    @(negedge clk);
    chk("fin_done_low", int'(done_draw_screen), 0);
    chk("fin_n_first", n_acc, 28);
    repeat (3) @(negedge clk);
    chk("fin_done_low2", int'(done_draw_screen), 0);
    wait_done(dc);
    chk("fin_n_total", n_acc, 56);
    check_order("fin_order", 28);
    check_scen(1);

    // Reset in the middle of WRITE
    apply(2);
    clear_log();
    pulse();
    wait_acc(5, "rst_reach5");
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_done", int'(done_draw_screen), 0);
    na = n_acc;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (70) @(negedge clk);
    chk("midrst_no_writes", n_acc, na);
    chk("midrst_done_low", int'(done_draw_screen), 0);
    render(0, 1'b1, dc);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
